// File: rtl/frac_stepper_if.sv
// Configuration, strobe and pixel-result bundle for frac_stepper.
// The master drives config and strobes; the slave returns pixel results.
interface frac_stepper_if #(
  parameter int BITWIDTH  = 11,
  parameter int FRACWIDTH = 16
);
  logic [BITWIDTH+FRACWIDTH-1:0] stepsize;
  logic [FRACWIDTH-1:0]          phase;
  logic [BITWIDTH-1:0]           offset;
  logic [BITWIDTH-1:0]           limit;
  logic                          mode;
  logic                          step_reset;
  logic                          step_in;
  logic                          out_valid;
  logic [BITWIDTH-1:0]           whole;
  logic [FRACWIDTH-1:0]          fraction;
  logic [BITWIDTH-1:0]           advance;
  logic                          blank;

  modport master (
    output stepsize, phase, offset, limit, mode,
    output step_reset, step_in,
    input  out_valid, whole, fraction, advance, blank
  );

  modport slave (
    input  stepsize, phase, offset, limit, mode,
    input  step_reset, step_in,
    output out_valid, whole, fraction, advance, blank
  );
endinterface

// File: rtl/frac_stepper.sv
// Fractional source-position generator: per destination strobe emits
// source index, interpolation fraction, advance count and blank flag.
module frac_stepper #(
  parameter int BITWIDTH  = 11,
  parameter int FRACWIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  frac_stepper_if.slave  bus
);
  localparam int W = BITWIDTH + FRACWIDTH;

  typedef enum logic [1:0] {
    S_IDLE, S_OFFSET, S_ACTIVE, S_DONE
  } state_t;

  state_t r_state, w_state_nx;

  logic [W-1:0]          r_acc;
  logic [BITWIDTH-1:0]   r_offcnt;
  logic [W-1:0]          r_step;
  logic [BITWIDTH-1:0]   r_limit;
  logic                  r_mode;

  logic                  r_valid;
  logic [BITWIDTH-1:0]   r_whole;
  logic [FRACWIDTH-1:0]  r_frac;
  logic [BITWIDTH-1:0]   r_adv;
  logic                  r_blank;

  logic [W:0]            w_sum;
  logic                  w_carry;
  logic [W-1:0]          w_acc_nx;
  logic [BITWIDTH-1:0]   w_pw;
  logic [FRACWIDTH-1:0]  w_pf;
  logic [BITWIDTH-1:0]   w_ew;
  logic [FRACWIDTH-1:0]  w_ef;
  logic                  w_oob;
  logic [BITWIDTH-1:0]   w_step_adv;
  logic                  w_fire;

  logic [BITWIDTH-1:0]   w_whole;
  logic [FRACWIDTH-1:0]  w_frac;
  logic [BITWIDTH-1:0]   w_adv;
  logic                  w_blank;

  assign w_sum    = {1'b0, r_acc} + {1'b0, r_step};
  assign w_carry  = w_sum[W];
  assign w_acc_nx = w_carry ? '1 : w_sum[W-1:0];
  assign w_pw     = r_acc[W-1:FRACWIDTH];
  assign w_pf     = r_acc[FRACWIDTH-1:0];
  // Nearest rounds half up; the add wraps at the index width.
  assign w_ew     = r_mode ? w_pw
                  : w_pw + {{(BITWIDTH-1){1'b0}}, w_pf[FRACWIDTH-1]};
  assign w_ef     = r_mode ? w_pf : '0;
  assign w_oob    = (w_ew >= r_limit);
  assign w_step_adv = w_acc_nx[W-1:FRACWIDTH] - w_pw;
  assign w_fire   = bus.step_in & ~bus.step_reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (bus.step_reset) begin
      w_state_nx = (bus.offset != '0) ? S_OFFSET : S_ACTIVE;
    end else if (bus.step_in) begin
      unique case (r_state)
        S_OFFSET: if (r_offcnt <= 1) w_state_nx = S_ACTIVE;
        S_ACTIVE: if (w_oob || w_carry) w_state_nx = S_DONE;
        default:  w_state_nx = r_state;
      endcase
    end
  end

  always_comb begin
    w_whole = '0;
    w_frac  = '0;
    w_adv   = '0;
    w_blank = 1'b1;
    unique case (r_state)
      S_ACTIVE: begin
        w_whole = w_ew;
        w_frac  = w_ef;
        w_adv   = w_oob ? '0 : w_step_adv;
        w_blank = w_oob;
      end
      S_DONE:  w_whole = r_limit;
      default: w_whole = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_offcnt <= '0;
      r_step   <= '0;
      r_limit  <= '0;
      r_mode   <= 1'b0;
      r_valid  <= 1'b0;
      r_whole  <= '0;
      r_frac   <= '0;
      r_adv    <= '0;
      r_blank  <= 1'b1;
    end else begin
      r_valid <= w_fire;
      if (bus.step_reset) begin
        r_step   <= bus.stepsize;
        r_limit  <= bus.limit;
        r_mode   <= bus.mode;
        r_acc    <= {{BITWIDTH{1'b0}}, bus.phase};
        r_offcnt <= bus.offset;
      end else if (bus.step_in) begin
        if (r_state == S_OFFSET) r_offcnt <= r_offcnt - 1'b1;
        if (r_state == S_ACTIVE) r_acc <= w_acc_nx;
        r_whole <= w_whole;
        r_frac  <= w_frac;
        r_adv   <= w_adv;
        r_blank <= w_blank;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.whole     = r_whole;
  assign bus.fraction  = r_frac;
  assign bus.advance   = r_adv;
  assign bus.blank     = r_blank;
endmodule

// File: tb/tb_frac_stepper.sv
// Bench for frac_stepper: table vectors through a scoreboard queue,
// plus hand sequences for collisions, limits, carry and reset.
module tb_frac_stepper;
  localparam int B = 11;
  localparam int F = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  frac_stepper_if #(.BITWIDTH(B), .FRACWIDTH(F)) bus ();

  frac_stepper #(.BITWIDTH(B), .FRACWIDTH(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [B-1:0] whole;
    logic [F-1:0] frac;
    logic [B-1:0] adv;
    logic         blank;
  } exp_t;

  typedef struct {
    bit             cfg;
    logic [B+F-1:0] step;
    logic [F-1:0]   phase;
    logic [B-1:0]   off;
    logic [B-1:0]   lim;
    logic           mode;
    exp_t           e;
  } vec_t;

  exp_t q[$];
  vec_t vt[22];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("whole", 32'(bus.whole), 32'(e.whole));
        chk("fraction", 32'(bus.fraction), 32'(e.frac));
        chk("advance", 32'(bus.advance), 32'(e.adv));
        chk("blank", 32'(bus.blank), 32'(e.blank));
      end
    end
  end

  function automatic exp_t ex(int w, int f, int a, int b);
    exp_t e;
    e.whole = B'(w);
    e.frac  = F'(f);
    e.adv   = B'(a);
    e.blank = b[0];
    return e;
  endfunction

  function automatic vec_t mk(bit c, int s, int p, int o, int l, int m,
                              int w, int f, int a, int b);
    vec_t v;
    v.cfg   = c;
    v.step  = (B+F)'(s);
    v.phase = F'(p);
    v.off   = B'(o);
    v.lim   = B'(l);
    v.mode  = m[0];
    v.e     = ex(w, f, a, b);
    return v;
  endfunction

  task automatic set_cfg(int s, int p, int o, int l, int m);
    bus.stepsize = (B+F)'(s);
    bus.phase    = F'(p);
    bus.offset   = B'(o);
    bus.limit    = B'(l);
    bus.mode     = m[0];
  endtask

  task automatic do_cfg(int s, int p, int o, int l, int m);
    set_cfg(s, p, o, l, m);
    bus.step_reset = 1'b1;
    @(posedge clk); #1;
    bus.step_reset = 1'b0;
    set_cfg(32'h7ff_ffff, 16'h1234, 11'd5, 11'd1, 0);
  endtask

  task automatic do_step(exp_t e);
    bus.step_in = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    bus.step_in = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(1, 'h10000, 0, 0, 4, 1,  0, 0, 1, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0,        1, 0, 1, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0,        2, 0, 1, 0);
    vt[3]  = mk(0, 0, 0, 0, 0, 0,        3, 0, 1, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 0,        4, 0, 0, 1);
    vt[5]  = mk(0, 0, 0, 0, 0, 0,        4, 0, 0, 1);
    vt[6]  = mk(1, 'h08000, 0, 0, 16, 1, 0, 0, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 0,        0, 'h8000, 1, 0);
    vt[8]  = mk(0, 0, 0, 0, 0, 0,        1, 0, 0, 0);
    vt[9]  = mk(0, 0, 0, 0, 0, 0,        1, 'h8000, 1, 0);
    vt[10] = mk(1, 'h08000, 0, 0, 16, 0, 0, 0, 0, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0,        1, 0, 1, 0);
    vt[12] = mk(0, 0, 0, 0, 0, 0,        1, 0, 0, 0);
    vt[13] = mk(0, 0, 0, 0, 0, 0,        2, 0, 1, 0);
    vt[14] = mk(1, 'h28000, 'h4000, 0, 16, 1, 0, 'h4000, 2, 0);
    vt[15] = mk(0, 0, 0, 0, 0, 0,        2, 'hC000, 3, 0);
    vt[16] = mk(0, 0, 0, 0, 0, 0,        5, 'h4000, 2, 0);
    vt[17] = mk(0, 0, 0, 0, 0, 0,        7, 'hC000, 3, 0);
    vt[18] = mk(1, 'h10000, 0, 3, 16, 1, 0, 0, 0, 1);
    vt[19] = mk(0, 0, 0, 0, 0, 0,        0, 0, 0, 1);
    vt[20] = mk(0, 0, 0, 0, 0, 0,        0, 0, 0, 1);
    vt[21] = mk(0, 0, 0, 0, 0, 0,        0, 0, 1, 0);

    bus.step_reset = 1'b0;
    bus.step_in    = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_whole", 32'(bus.whole), 32'd0);
    chk("rst_fraction", 32'(bus.fraction), 32'd0);
    chk("rst_advance", 32'(bus.advance), 32'd0);
    chk("rst_blank", 32'(bus.blank), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    do_step(ex(0, 0, 0, 1));

    for (int i = 0; i < 22; i++) begin
      if (vt[i].cfg)
        do_cfg(vt[i].step, vt[i].phase, vt[i].off, vt[i].lim, vt[i].mode);
      do_step(vt[i].e);
    end

    // Stepsize change without step_reset must be ignored.
    bus.stepsize = 27'h30000;
    do_step(ex(1, 0, 1, 0));
    do_step(ex(2, 0, 1, 0));

    set_cfg('h10000, 'h2000, 0, 16, 1);
    bus.step_reset = 1'b1;
    bus.step_in    = 1'b1;
    @(posedge clk); #1;
    bus.step_reset = 1'b0;
    bus.step_in    = 1'b0;
    @(negedge clk);
    chk("coll_hold_whole", 32'(bus.whole), 32'd2);
    chk("coll_no_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    do_step(ex(0, 'h2000, 1, 0));
    do_step(ex(1, 'h2000, 1, 0));

    do_cfg('h10000, 0, 0, 0, 1);
    do_step(ex(0, 0, 0, 1));
    do_step(ex(0, 0, 0, 1));

    do_cfg(0, 'h8000, 0, 16, 0);
    do_step(ex(1, 0, 0, 0));
    do_step(ex(1, 0, 0, 0));

    do_cfg('h7000000, 0, 0, 'h7FF, 1);
    do_step(ex(0, 0, 'h700, 0));
    do_step(ex('h700, 0, 'hFF, 0));
    do_step(ex('h7FF, 0, 0, 1));

    do_cfg('h10000, 0, 0, 16, 1);
    do_step(ex(0, 0, 1, 0));
    do_step(ex(1, 0, 1, 0));
    idle(1);
    reset = 1'b1;
    bus.step_in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.step_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_whole", 32'(bus.whole), 32'd0);
    chk("mid_rst_blank", 32'(bus.blank), 32'd1);
    @(posedge clk); #1;
    do_step(ex(0, 0, 0, 1));

    idle(3);
    chk("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
